encoder: RTL and testbench

ENCODER -- requirements
Module: encoder

---
 rtl/encoder.sv | 58 +++++
 tb/tb_encoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/encoder.sv
// Serial-in Hamming(7,4) encoder.
// Bits arrive one per write strobe (d1 first); once four bits are collected
// the codeword is registered on data_out and valid pulses for one cycle.
module encoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  input  logic       write,
  output logic [6:0] data_out,
  output logic       valid
);

  // Position of the next incoming bit within the current nibble (0..3)
  logic [1:0] bit_count;
  // Partial nibble, oldest bit in the MSB: after three bits {d1,d2,d3}
  logic [2:0] hold_reg;
  // Codeword that would be produced if the current bit completes the nibble
  logic [6:0] next_code;

  logic d1, d2, d3, d4;
  logic p1, p2, p4;

  // Form the even-parity codeword from the held bits and the live input bit
  always_comb begin
    d1 = hold_reg[2];
    d2 = hold_reg[1];
    d3 = hold_reg[0];
    d4 = data_in;
    p1 = d1 ^ d2 ^ d4;
    p2 = d1 ^ d3 ^ d4;
    p4 = d2 ^ d3 ^ d4;
    next_code = {p1, p2, d1, p4, d2, d3, d4};
  end

  // Collect bits, publish the codeword on the fourth one, pulse valid once
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_count <= 2'd0;
      hold_reg  <= 3'b000;
      data_out  <= 7'b0000000;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (write) begin
        if (bit_count == 2'd3) begin
          data_out  <= next_code;
          valid     <= 1'b1;
          bit_count <= 2'd0;
          hold_reg  <= 3'b000;
        end else begin
          hold_reg  <= {hold_reg[1:0], data_in};
          bit_count <= bit_count + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_encoder.sv
// Directed self-checking bench for the serial Hamming(7,4) encoder.
module tb_encoder;

  logic       clk;
  logic       reset;
  logic       data_in;
  logic       write;
  logic [6:0] data_out;
  logic       valid;

  int assertCount;
  int failCount;
  int validSeen;
  int minDist;
  logic [6:0] observed [16];

  encoder dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .write    (write),
    .data_out (data_out),
    .valid    (valid)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Independent reference: XOR of generator rows for each set data bit
  function automatic logic [6:0] refCode(input logic [3:0] nib);
    logic [6:0] c;
    c = 7'b0000000;
    if (nib[3]) c = c ^ 7'b1110000;
    if (nib[2]) c = c ^ 7'b1001100;
    if (nib[1]) c = c ^ 7'b0101010;
    if (nib[0]) c = c ^ 7'b1101001;
    return c;
  endfunction

  // Syndrome over Hamming positions 1..7 mapped to bits 6..0
  function automatic logic [2:0] syndrome(input logic [6:0] c);
    logic s1, s2, s4;
    s1 = c[6] ^ c[4] ^ c[2] ^ c[0];
    s2 = c[5] ^ c[4] ^ c[1] ^ c[0];
    s4 = c[3] ^ c[2] ^ c[1] ^ c[0];
    return {s4, s2, s1};
  endfunction

  // Drive one cycle of inputs at the falling edge, return just after the rising edge
  task automatic applyStimulus(input logic r, input logic w, input logic d);
    @(negedge clk);
    reset   = r;
    write   = w;
    data_in = d;
    @(posedge clk);
    #1;
    if (valid === 1'b1) validSeen++;
  endtask

  task automatic checkOutput(input string tag, input logic [6:0] expData, input logic expValid);
    assertCount++;
    assert (data_out === expData) else begin
      failCount++;
      $error("[TB] FAIL %s data_out: observed %b expected %b", tag, data_out, expData);
    end
    assertCount++;
    assert (valid === expValid) else begin
      failCount++;
      $error("[TB] FAIL %s valid: observed %b expected %b", tag, valid, expValid);
    end
  endtask

  // Feed a nibble MSB (d1) first on consecutive edges, checking hold then publish
  task automatic sendNibble(input string tag, input logic [3:0] nib,
                            input logic [6:0] prevCode, input logic [6:0] expCode);
    for (int i = 3; i >= 1; i--) begin
      applyStimulus(1'b0, 1'b1, nib[i]);
      checkOutput({tag, "_partial"}, prevCode, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, nib[0]);
    checkOutput(tag, expCode, 1'b1);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    validSeen   = 0;
    reset   = 1'b1;
    write   = 1'b0;
    data_in = 1'b0;

    $display("[TB] start");
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("reset", 7'b0000000, 1'b0);

    sendNibble("n1001", 4'b1001, 7'b0000000, 7'b0011001);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("n1001_after", 7'b0011001, 1'b0);

    sendNibble("n1011", 4'b1011, 7'b0011001, 7'b0110011);
    sendNibble("n1111", 4'b1111, 7'b0110011, 7'b1111111);
    sendNibble("n0000", 4'b0000, 7'b1111111, 7'b0000000);

    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, i[0]);
      checkOutput("gap", 7'b0000000, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("gap_third", 7'b0000000, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("gap_done", 7'b0011001, 1'b1);

    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("mid_reset", 7'b0000000, 1'b0);
    sendNibble("post_reset", 4'b1001, 7'b0000000, 7'b0011001);

    applyStimulus(1'b1, 1'b0, 1'b0);
    validSeen = 0;
    sendNibble("stream_a", 4'b1001, 7'b0000000, 7'b0011001);
    sendNibble("stream_b", 4'b1011, 7'b0011001, 7'b0110011);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stream_idle", 7'b0110011, 1'b0);
    assertCount++;
    assert (validSeen == 2) else begin
      failCount++;
      $error("[TB] FAIL stream_valid_count: observed %0d expected 2", validSeen);
    end

    for (int n = 0; n < 16; n++) begin
      logic [3:0] nib;
      nib = n[3:0];
      applyStimulus(1'b0, 1'b1, nib[3]);
      applyStimulus(1'b0, 1'b1, nib[2]);
      applyStimulus(1'b0, 1'b1, nib[1]);
      applyStimulus(1'b0, 1'b1, nib[0]);
      checkOutput($sformatf("exh_%0d", n), refCode(nib), 1'b1);
      observed[n] = data_out;
      assertCount++;
      assert (syndrome(data_out) === 3'b000) else begin
        failCount++;
        $error("[TB] FAIL exh_%0d syndrome: observed %b expected 000", n, syndrome(data_out));
      end
    end

    minDist = 7;
    for (int a = 0; a < 16; a++) begin
      for (int b = a + 1; b < 16; b++) begin
        if ($countones(observed[a] ^ observed[b]) < minDist)
          minDist = $countones(observed[a] ^ observed[b]);
      end
    end
    assertCount++;
    assert (minDist >= 3) else begin
      failCount++;
      $error("[TB] FAIL min_distance: observed %0d expected >=3", minDist);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
